multi_cycle_ctrl: RTL and testbench

//   Multi-cycle MIPS control unit: FSM sequencing IF/ID/EX/MEM/WB per instruction.

---
 rtl/multi_cycle_ctrl_if.sv | 53 +++++
 rtl/multi_cycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - control-unit <-> datapath/memory signal bundle
// Purpose: groups the decode inputs, memory handshake and datapath strobes of
//   the multi-cycle MIPS control unit.
// Ports (members):
//   op/func/z          IR fields and ALU zero flag (datapath -> ctrl)
//   mem_ready          memory completes current access (memory -> ctrl)
//   mem_req/iord/rmem/wmem  memory request, address select, read/write
//   ir_we/pc_we/pcsource    IR and PC load controls
//   sext/regrt/alusrc/shift/aluc/jal/m2reg/wreg  datapath selects and strobes
//   illegal/bus_err    one-cycle error pulses
//   state/instret      current FSM state and retired-instruction count
// Modports: master = control unit, slave = datapath/memory side.
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             z;
  logic             mem_ready;
  logic             mem_req;
  logic             iord;
  logic             rmem;
  logic             wmem;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pcsource;
  logic             sext;
  logic             regrt;
  logic             alusrc;
  logic             shift;
  logic [3:0]       aluc;
  logic             jal;
  logic             m2reg;
  logic             wreg;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, func, z, mem_ready,
    output mem_req, iord, rmem, wmem, ir_we, pc_we, pcsource,
           sext, regrt, alusrc, shift, aluc, jal, m2reg, wreg,
           illegal, bus_err, state, instret
  );

  modport slave (
    output op, func, z, mem_ready,
    input  mem_req, iord, rmem, wmem, ir_we, pc_we, pcsource,
           sext, regrt, alusrc, shift, aluc, jal, m2reg, wreg,
           illegal, bus_err, state, instret
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control unit (IF/ID/EX/MEM/WB FSM)
// Purpose: sequences each instruction through IF/ID/EX/MEM/WB, drives datapath
//   strobes and mux selects, handshakes with the shared memory and counts
//   retired instructions.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; all outputs forced to 0 while low
//   bus    multi_cycle_ctrl_if.master (decode inputs, memory handshake, strobes)
// Parameters:
//   TIMEOUT  max cycles mem_req may wait for mem_ready (0 = never time out)
//   CNT_W    width of instret
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_cycle_ctrl_if.master  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_SHIFT, C_JR, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  cls_t       cls;
  logic [3:0] aluc_dec;
  logic       sext_dec;

  logic       mem_req, iord, rmem, wmem, ir_we, pc_we;
  logic [1:0] pcsource;
  logic       sext, regrt, alusrc, shift, jal, m2reg, wreg, illegal, bus_err;
  logic [3:0] aluc;
  logic       tmo;

  // Instruction class and ALU op; op/func are stable from ID to the next IF,
  // so the same decode feeds every post-fetch state.
  always_comb begin
    cls      = C_ILL;
    aluc_dec = 4'b0000;
    sext_dec = 1'b0;
    case (bus.op)
      6'h00: begin
        case (bus.func)
          6'h20: begin cls = C_RALU;  aluc_dec = 4'b0000; end
          6'h22: begin cls = C_RALU;  aluc_dec = 4'b0100; end
          6'h24: begin cls = C_RALU;  aluc_dec = 4'b0001; end
          6'h25: begin cls = C_RALU;  aluc_dec = 4'b0101; end
          6'h26: begin cls = C_RALU;  aluc_dec = 4'b0010; end
          6'h00: begin cls = C_SHIFT; aluc_dec = 4'b0011; end
          6'h02: begin cls = C_SHIFT; aluc_dec = 4'b0111; end
          6'h03: begin cls = C_SHIFT; aluc_dec = 4'b1111; end
          6'h08: cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      6'h08: begin cls = C_IMM; aluc_dec = 4'b0000; sext_dec = 1'b1; end
      6'h0C: begin cls = C_IMM; aluc_dec = 4'b0001; end
      6'h0D: begin cls = C_IMM; aluc_dec = 4'b0101; end
      6'h0E: begin cls = C_IMM; aluc_dec = 4'b0010; end
      6'h0F: begin cls = C_IMM; aluc_dec = 4'b0110; end
      6'h23: begin cls = C_LW;  sext_dec = 1'b1; end
      6'h2B: begin cls = C_SW;  sext_dec = 1'b1; end
      6'h04: begin cls = C_BEQ; aluc_dec = 4'b0100; end
      6'h05: begin cls = C_BNE; aluc_dec = 4'b0100; end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    iord     = 1'b0;
    rmem     = 1'b0;
    wmem     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pcsource = 2'b00;
    sext     = 1'b0;
    regrt    = 1'b0;
    alusrc   = 1'b0;
    shift    = 1'b0;
    aluc     = 4'b0000;
    jal      = 1'b0;
    m2reg    = 1'b0;
    wreg     = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    tmo      = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT));

    // Selects are held for the whole EX..WB span of an instruction.
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      sext   = sext_dec;
      regrt  = (cls == C_IMM) || (cls == C_LW);
      alusrc = (cls == C_IMM) || (cls == C_LW) || (cls == C_SW);
      shift  = (cls == C_SHIFT);
      aluc   = aluc_dec;
    end

    case (state_q)
      S_IF: begin
        if (tmo) begin
          bus_err = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_ID;
          end
        end
      end
      S_ID: begin
        if (cls == C_ILL) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        case (cls)
          C_RALU, C_SHIFT, C_IMM: state_d = S_WB;
          C_LW, C_SW:             state_d = S_MEM;
          C_JR:  begin pcsource = 2'b10; pc_we = 1'b1;   retire = 1'b1; end
          C_BEQ: begin pcsource = 2'b01; pc_we = bus.z;  retire = 1'b1; end
          C_BNE: begin pcsource = 2'b01; pc_we = !bus.z; retire = 1'b1; end
          C_J:   begin pcsource = 2'b11; pc_we = 1'b1;   retire = 1'b1; end
          C_JAL: begin
            pcsource = 2'b11;
            pc_we    = 1'b1;
            jal      = 1'b1;
            wreg     = 1'b1;
            retire   = 1'b1;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (tmo) begin
          bus_err = 1'b1;
          state_d = S_IF;
        end else begin
          mem_req = 1'b1;
          iord    = 1'b1;
          rmem    = (cls == C_LW);
          wmem    = (cls == C_SW);
          if (bus.mem_ready) begin
            if (cls == C_LW) begin
              state_d = S_WB;
            end else begin
              state_d = S_IF;
              retire  = 1'b1;
            end
          end
        end
      end
      S_WB: begin
        wreg    = 1'b1;
        m2reg   = (cls == C_LW);
        state_d = S_IF;
        retire  = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    // Wait counter only advances while a request is stalled in one state.
    if (!mem_req || bus.mem_ready || tmo || state_d != state_q) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    if (!rst_n) begin
      mem_req = 1'b0; iord = 1'b0; rmem = 1'b0; wmem = 1'b0;
      ir_we = 1'b0; pc_we = 1'b0; pcsource = 2'b00;
      sext = 1'b0; regrt = 1'b0; alusrc = 1'b0; shift = 1'b0; aluc = 4'b0000;
      jal = 1'b0; m2reg = 1'b0; wreg = 1'b0; illegal = 1'b0; bus_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      tcnt_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.iord     = iord;
  assign bus.rmem     = rmem;
  assign bus.wmem     = wmem;
  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.pcsource = pcsource;
  assign bus.sext     = sext;
  assign bus.regrt    = regrt;
  assign bus.alusrc   = alusrc;
  assign bus.shift    = shift;
  assign bus.aluc     = aluc;
  assign bus.jal      = jal;
  assign bus.m2reg    = m2reg;
  assign bus.wreg     = wreg;
  assign bus.illegal  = illegal;
  assign bus.bus_err  = bus_err;
  assign bus.state    = rst_n ? state_q : 3'd0;
  assign bus.instret  = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.CNT_W(32)) bus ();

  multi_cycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Control vector layout:
  // 21 mem_req 20 iord 19 rmem 18 wmem 17 ir_we 16 pc_we 15:14 pcsource
  // 13 sext 12 regrt 11 alusrc 10 shift 9:6 aluc 5 jal 4 m2reg 3 wreg
  // 2 illegal 1 bus_err 0 zero
  localparam logic [21:0] MREQ    = 22'd1 << 21;
  localparam logic [21:0] IORD    = 22'd1 << 20;
  localparam logic [21:0] RMEM    = 22'd1 << 19;
  localparam logic [21:0] WMEM    = 22'd1 << 18;
  localparam logic [21:0] IRWE    = 22'd1 << 17;
  localparam logic [21:0] PCWE    = 22'd1 << 16;
  localparam logic [21:0] SEXT    = 22'd1 << 13;
  localparam logic [21:0] REGRT   = 22'd1 << 12;
  localparam logic [21:0] ALUSRC  = 22'd1 << 11;
  localparam logic [21:0] SHIFT   = 22'd1 << 10;
  localparam logic [21:0] JAL     = 22'd1 << 5;
  localparam logic [21:0] M2REG   = 22'd1 << 4;
  localparam logic [21:0] WREG    = 22'd1 << 3;
  localparam logic [21:0] ILLEGAL = 22'd1 << 2;
  localparam logic [21:0] BUSERR  = 22'd1 << 1;

  function automatic logic [21:0] pcs(input logic [1:0] v);
    return {6'd0, v, 14'd0};
  endfunction

  function automatic logic [21:0] alu(input logic [3:0] v);
    return {12'd0, v, 6'd0};
  endfunction

  typedef struct {
    logic [2:0]  st;
    logic [21:0] ctl;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycno  = 0;

  // Drive one cycle of inputs and queue the response the DUT owes for it.
  task automatic cyc(input logic rn, input logic [5:0] o, input logic [5:0] f,
                     input logic zz, input logic mr, input logic [2:0] st,
                     input logic [21:0] c, input logic [31:0] r);
    exp_t e;
    rst_n         = rn;
    bus.op        = o;
    bus.func      = f;
    bus.z         = zz;
    bus.mem_ready = mr;
    e.st  = st;
    e.ctl = c;
    e.ret = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] o, input logic [5:0] f, input logic [31:0] r);
    cyc(1'b1, o, f, 1'b0, 1'b1, 3'd0, MREQ | IRWE | PCWE, r);
    cyc(1'b1, o, f, 1'b0, 1'b1, 3'd1, 22'd0, r);
  endtask

  logic [21:0] act_ctl;
  assign act_ctl = {bus.mem_req, bus.iord, bus.rmem, bus.wmem, bus.ir_we, bus.pc_we,
                    bus.pcsource, bus.sext, bus.regrt, bus.alusrc, bus.shift, bus.aluc,
                    bus.jal, bus.m2reg, bus.wreg, bus.illegal, bus.bus_err, 1'b0};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (bus.state !== e.st) begin
        n_fail++;
        $display("FAIL state cyc=%0d actual=%0d required=%0d", cycno, bus.state, e.st);
      end
      n_chk++;
      if (act_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d actual=%06h required=%06h", cycno, act_ctl, e.ctl);
      end
      n_chk++;
      if (bus.instret !== e.ret) begin
        n_fail++;
        $display("FAIL instret cyc=%0d actual=%0d required=%0d", cycno, bus.instret, e.ret);
      end
      cycno++;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.op = 6'h00;
    bus.func = 6'h00;
    bus.z = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset: everything zero
    cyc(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 3'd0, 22'd0, 0);
    cyc(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 3'd0, 22'd0, 0);

    // add: 0,1,2,4,0
    fetch(6'h00, 6'h20, 0);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd2, 22'd0, 0);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd4, WREG, 0);

    // sub
    fetch(6'h00, 6'h22, 1);
    cyc(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 3'd2, alu(4'b0100), 1);
    cyc(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 3'd4, WREG | alu(4'b0100), 1);

    // lw with three stall cycles in MEM
    fetch(6'h23, 6'h00, 2);
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 3'd2, SEXT | REGRT | ALUSRC, 2);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 3'd3, MREQ | IORD | RMEM | SEXT | REGRT | ALUSRC, 2);
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 3'd3, MREQ | IORD | RMEM | SEXT | REGRT | ALUSRC, 2);
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 3'd4, WREG | M2REG | SEXT | REGRT | ALUSRC, 2);

    // sw retires in MEM
    fetch(6'h2B, 6'h00, 3);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd2, SEXT | ALUSRC, 3);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd3, MREQ | IORD | WMEM | SEXT | ALUSRC, 3);

    // beq/bne, both z values
    fetch(6'h04, 6'h00, 4);
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 3'd2, alu(4'b0100) | pcs(2'b01) | PCWE, 4);
    fetch(6'h04, 6'h00, 5);
    cyc(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 3'd2, alu(4'b0100) | pcs(2'b01), 5);
    fetch(6'h05, 6'h00, 6);
    cyc(1'b1, 6'h05, 6'h00, 1'b1, 1'b1, 3'd2, alu(4'b0100) | pcs(2'b01), 6);
    fetch(6'h05, 6'h00, 7);
    cyc(1'b1, 6'h05, 6'h00, 1'b0, 1'b1, 3'd2, alu(4'b0100) | pcs(2'b01) | PCWE, 7);

    // jal, jr
    fetch(6'h03, 6'h00, 8);
    cyc(1'b1, 6'h03, 6'h00, 1'b0, 1'b1, 3'd2, PCWE | pcs(2'b11) | JAL | WREG, 8);
    fetch(6'h00, 6'h08, 9);
    cyc(1'b1, 6'h00, 6'h08, 1'b0, 1'b1, 3'd2, PCWE | pcs(2'b10), 9);

    // addi, lui, sra
    fetch(6'h08, 6'h00, 10);
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 3'd2, SEXT | REGRT | ALUSRC, 10);
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 3'd4, SEXT | REGRT | ALUSRC | WREG, 10);
    fetch(6'h0F, 6'h00, 11);
    cyc(1'b1, 6'h0F, 6'h00, 1'b0, 1'b1, 3'd2, REGRT | ALUSRC | alu(4'b0110), 11);
    cyc(1'b1, 6'h0F, 6'h00, 1'b0, 1'b1, 3'd4, REGRT | ALUSRC | alu(4'b0110) | WREG, 11);
    fetch(6'h00, 6'h03, 12);
    cyc(1'b1, 6'h00, 6'h03, 1'b0, 1'b1, 3'd2, SHIFT | alu(4'b1111), 12);
    cyc(1'b1, 6'h00, 6'h03, 1'b0, 1'b1, 3'd4, SHIFT | alu(4'b1111) | WREG, 12);

    // illegal op and illegal func: pulse in ID, not retired
    cyc(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd0, MREQ | IRWE | PCWE, 13);
    cyc(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 3'd1, ILLEGAL, 13);
    cyc(1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 3'd0, MREQ | IRWE | PCWE, 13);
    cyc(1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 3'd1, ILLEGAL, 13);

    // fetch timeout: 16 wait cycles then bus_err, counter restarts
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 3'd0, MREQ, 13);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 3'd0, BUSERR, 13);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 3'd0, MREQ, 13);
    fetch(6'h00, 6'h20, 13);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd2, 22'd0, 13);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd4, WREG, 13);

    // reset during sw MEM: write dropped, counter cleared
    fetch(6'h2B, 6'h00, 14);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd2, SEXT | ALUSRC, 14);
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 3'd3, MREQ | IORD | WMEM | SEXT | ALUSRC, 14);
    cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd0, 22'd0, 0);
    fetch(6'h00, 6'h20, 0);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd2, 22'd0, 0);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 3'd4, WREG, 0);
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 3'd0, MREQ, 1);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
